decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Instruction-decode stage sitting between fetch and execute.
- Accepts a 16-bit instruction from fetch over a valid/ready handshake and drives the register file read addresses (ra, rb).
- Captures the register file read data (a, b) into an ID/EX pipeline register with a valid/ready handshake toward execute.
- Keeps an 8-entry scoreboard of in-flight destination registers, cleared by writeback, and stalls fetch on read-after-write hazards.

Parameters:
- WIDTH, 16, datapath width; matches register_file WIDTH.
- NREGS, 8, architectural register count; register addresses are 3 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- if_valid  in  1  fetch presents an instruction.
- if_instr  in  16  instruction word.
- if_pc  in  16  PC of the instruction.
- if_ready  out  1  decode accepts the instruction this cycle.
- rf_ra  out  3  register file read port A address (rs1).
- rf_rb  out  3  register file read port B address (rs2).
- rf_a  in  WIDTH  register file port A data; combinational read.
- rf_b  in  WIDTH  register file port B data; combinational read.
- wb_valid  in  1  writeback is writing the register file this cycle.
- wb_addr  in  3  writeback destination register.
- id_valid  out  1  ID/EX register holds a valid instruction.
- ex_ready  in  1  execute consumes the ID/EX contents this cycle.
- id_opcode  out  4  decoded opcode.
- id_rd  out  3  destination register.
- id_op_a  out  WIDTH  rs1 value.
- id_op_b  out  WIDTH  rs2 value, or the sign-extended imm6 for I-format.
- id_pc  out  16  PC of the instruction.
- id_illegal  out  1  opcode 8-15 was received.
- stall_cnt  out  16  saturating count of hazard-stall cycles.

Behaviour:
- Instruction format:
  - [15:12] opcode; [11:9] rd; [8:6] rs1.
  - R-format: [5:3] rs2.
  - I-format: [5:0] imm6.
- Opcode map:
  - 0 NOP: no reads, no write.
  - 1 ADD, 2 SUB, 3 AND, 4 OR: R-format; read rs1 and rs2; write rd.
  - 5 ADDI, 6 LD: I-format; read rs1; write rd.
  - 7 BEQ: rs2 in [11:9]; read rs1 and rs2; no write.
  - 8-15: illegal; treated as NOP with id_illegal=1.
- Register addresses:
  - rf_ra = if_instr[8:6] at all times.
  - rf_rb = [5:3], or [11:9] for opcode 7.
  - Both are combinational from if_instr.
- Register 0 reads as zero. Writes to rd=0 never set the scoreboard, and reads of r0 never hazard.
- Scoreboard: 8 pending bits, next-state = (pending & ~wb_clear) | issue_set.
  - wb_clear = one-hot(wb_addr) when wb_valid.
  - issue_set = one-hot(rd) when an instruction that writes rd (rd≠0) is accepted.
  - If wb and issue target the same register in the same cycle, set wins.
- Hazard: asserted when if_valid and a source that is actually read has its pending bit set.
  - A same-cycle wb_valid to that register does NOT remove the hazard. There is no bypass; the register file write lands at the edge.
- Handshake:
  - out_free = !id_valid || ex_ready.
  - if_ready = out_free && !hazard.
  - Accept = if_valid && if_ready.
- Latency: 1 cycle. On accept, the ID/EX register loads the decoded fields, rf_a/rf_b (or imm6 sign-extended to WIDTH), and if_pc; id_valid=1 next cycle.
- id_valid transitions:
  - ex_ready && !accept → id_valid=0, other ID/EX fields hold.
  - !ex_ready → all ID/EX outputs hold stable.
- stall_cnt increments each cycle with if_valid && hazard && out_free, and saturates at 0xFFFF. Backpressure from execute does not count.
- Reset (reset=0 at an edge) takes priority over all activity:
  - pending=0, stall_cnt=0.
  - id_valid=0, id_illegal=0.
  - id_opcode, id_rd, id_op_a, id_op_b, id_pc = 0.
- if_ready is combinational and may be 1 during reset.
- A mid-operation reset drops the in-flight ID/EX instruction and clears the scoreboard.

Decomposition:
- Shared package (cpu_pkg), shared with execute and writeback:
  - opcode constants OP_NOP..OP_BEQ.
  - field bit positions.
  - REG_ADDR_W=3.
  - an instr_fmt enum (R, I, B).
- One natural sub-module: scoreboard (8 pending bits, set/clear ports, two combinational lookup ports).
- Decode logic and the ID/EX register stay in decode_stage.

Test Plan:
- Reset, then ADD r1,r2,r3 (0x1298) with rf_a=5, rf_b=8, ex_ready=1:
  - accepted on that cycle; next cycle id_valid=1, id_opcode=1, id_rd=1, id_op_a=5, id_op_b=8.
  - pending[1]=1.
- ADD r1 followed by ADD r4,r1,r2 (0x1850):
  - if_ready=0, stall_cnt increments every cycle until wb_valid with wb_addr=1.
  - accepted the cycle AFTER the wb cycle; the same-cycle wb still stalls.
- ADDI r2,r0,-1 (0x543F):
  - id_op_b=0xFFFF.
  - a prior pending write to r0 never stalls; rd=2 is marked pending.
- Backpressure: hold ex_ready=0 for 3 cycles with id_valid=1:
  - all id_* outputs stable, if_ready=0, stall_cnt unchanged.
  - on release, the next instruction loads in the same cycle.
- Opcode 0xC in if_instr:
  - id_illegal=1, no pending bit set, no stall for the following instruction.
- Assert reset=0 while id_valid=1 and pending=0x06:
  - after the edge id_valid=0, pending=0, stall_cnt=0, all id_* outputs = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions, formats.
package cpu_pkg;

   localparam int unsigned REG_ADDR_W = 3;

   // Instruction field LSB positions
   localparam int unsigned OPC_LSB = 12;
   localparam int unsigned RD_LSB  = 9;
   localparam int unsigned RS1_LSB = 6;
   localparam int unsigned RS2_LSB = 3;
   localparam int unsigned IMM_W   = 6;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_ADDI = 4'd5;
   localparam logic [3:0] OP_LD   = 4'd6;
   localparam logic [3:0] OP_BEQ  = 4'd7;

   typedef enum logic [1:0] {FMT_R, FMT_I, FMT_B} instr_fmt_e;

   // NOP and illegal opcodes fall into FMT_R; their reads are masked elsewhere.
   function automatic instr_fmt_e fmt_of(input logic [3:0] op);
      case (op)
         OP_ADDI, OP_LD: fmt_of = FMT_I;
         OP_BEQ:         fmt_of = FMT_B;
         default:        fmt_of = FMT_R;
      endcase
   endfunction

endpackage

// File: rtl/decode_stage_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register.
module decode_stage_scoreboard
   import cpu_pkg::*;
#(
   parameter int unsigned NREGS = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_addr,
   input  logic                  clr_en,
   input  logic [REG_ADDR_W-1:0] clr_addr,
   input  logic [REG_ADDR_W-1:0] addr_a,
   input  logic [REG_ADDR_W-1:0] addr_b,
   output logic                  pend_a,
   output logic                  pend_b
);

   logic [NREGS-1:0] pending_q, pending_d;

   // Clear first, then set, so a same-cycle issue wins over writeback
   always_comb begin
      pending_d = pending_q;
      if (clr_en) pending_d[clr_addr] = 1'b0;
      if (set_en) pending_d[set_addr] = 1'b1;
   end

   // Pending state, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) pending_q <= '0;
      else        pending_q <= pending_d;
   end

   assign pend_a = pending_q[addr_a];
   assign pend_b = pending_q[addr_b];

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: register read addressing, RAW hazard stall,
// and the ID/EX pipeline register.
module decode_stage
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NREGS = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_valid,
   input  logic [15:0]           if_instr,
   input  logic [15:0]           if_pc,
   output logic                  if_ready,
   output logic [REG_ADDR_W-1:0] rf_ra,
   output logic [REG_ADDR_W-1:0] rf_rb,
   input  logic [WIDTH-1:0]      rf_a,
   input  logic [WIDTH-1:0]      rf_b,
   input  logic                  wb_valid,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   output logic                  id_valid,
   input  logic                  ex_ready,
   output logic [3:0]            id_opcode,
   output logic [REG_ADDR_W-1:0] id_rd,
   output logic [WIDTH-1:0]      id_op_a,
   output logic [WIDTH-1:0]      id_op_b,
   output logic [15:0]           id_pc,
   output logic                  id_illegal,
   output logic [15:0]           stall_cnt
);

   logic [3:0]            opcode;
   logic [REG_ADDR_W-1:0] rd, rs1, rs2;
   instr_fmt_e            fmt;
   logic                  illegal, reads_a, reads_b, writes_rd;
   logic                  pend_a, pend_b, hazard, out_free, accept;
   logic [WIDTH-1:0]      op_a_val, op_b_val, imm_ext;

   logic                  valid_q, illegal_q;
   logic [3:0]            opcode_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic [WIDTH-1:0]      op_a_q, op_b_q;
   logic [15:0]           pc_q, stall_q;

   assign opcode  = if_instr[OPC_LSB +: 4];
   assign rd      = if_instr[RD_LSB +: REG_ADDR_W];
   assign rs1     = if_instr[RS1_LSB +: REG_ADDR_W];
   assign rs2     = if_instr[RS2_LSB +: REG_ADDR_W];
   assign imm_ext = {{(WIDTH-IMM_W){if_instr[IMM_W-1]}}, if_instr[IMM_W-1:0]};

   // Field decode: which sources are read and whether rd is written
   always_comb begin
      fmt       = fmt_of(opcode);
      illegal   = opcode[3];
      reads_a   = !illegal && (opcode != OP_NOP);
      reads_b   = !illegal && ((fmt == FMT_B) || ((fmt == FMT_R) && (opcode != OP_NOP)));
      writes_rd = !illegal && (opcode != OP_NOP) && (opcode != OP_BEQ);
   end

   assign rf_ra = rs1;
   assign rf_rb = (fmt == FMT_B) ? rd : rs2;

   decode_stage_scoreboard #(
      .NREGS (NREGS)
   ) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .set_en   (accept && writes_rd && (rd != '0)),
      .set_addr (rd),
      .clr_en   (wb_valid),
      .clr_addr (wb_addr),
      .addr_a   (rf_ra),
      .addr_b   (rf_rb),
      .pend_a   (pend_a),
      .pend_b   (pend_b)
   );

   // No bypass: a same-cycle writeback still counts as a hazard
   always_comb begin
      hazard   = if_valid && ((reads_a && (rf_ra != '0) && pend_a) ||
                              (reads_b && (rf_rb != '0) && pend_b));
      out_free = !valid_q || ex_ready;
      if_ready = out_free && !hazard;
      accept   = if_valid && if_ready;
      op_a_val = (rf_ra == '0) ? '0 : rf_a;
      if (fmt == FMT_I)       op_b_val = imm_ext;
      else if (rf_rb == '0)   op_b_val = '0;
      else                    op_b_val = rf_b;
   end

   // ID/EX register: load on accept, drain on ex_ready, otherwise hold
   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         opcode_q  <= '0;
         rd_q      <= '0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         pc_q      <= '0;
      end else if (accept) begin
         valid_q   <= 1'b1;
         illegal_q <= illegal;
         opcode_q  <= opcode;
         rd_q      <= rd;
         op_a_q    <= op_a_val;
         op_b_q    <= op_b_val;
         pc_q      <= if_pc;
      end else if (ex_ready) begin
         valid_q   <= 1'b0;
      end
   end

   // Hazard stall counter; backpressure cycles are not counted
   always_ff @(posedge clk) begin
      if (!reset)                                           stall_q <= '0;
      else if (if_valid && hazard && out_free && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
   end

   assign id_valid   = valid_q;
   assign id_illegal = illegal_q;
   assign id_opcode  = opcode_q;
   assign id_rd      = rd_q;
   assign id_op_a    = op_a_q;
   assign id_op_b    = op_b_q;
   assign id_pc      = pc_q;
   assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

   localparam int unsigned WIDTH = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             if_valid;
   logic [15:0]      if_instr, if_pc;
   logic             if_ready;
   logic [2:0]       rf_ra, rf_rb;
   logic [WIDTH-1:0] rf_a, rf_b;
   logic             wb_valid;
   logic [2:0]       wb_addr;
   logic             id_valid, ex_ready;
   logic [3:0]       id_opcode;
   logic [2:0]       id_rd;
   logic [WIDTH-1:0] id_op_a, id_op_b;
   logic [15:0]      id_pc;
   logic             id_illegal;
   logic [15:0]      stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   decode_stage #(
      .WIDTH (WIDTH),
      .NREGS (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .if_valid   (if_valid),
      .if_instr   (if_instr),
      .if_pc      (if_pc),
      .if_ready   (if_ready),
      .rf_ra      (rf_ra),
      .rf_rb      (rf_rb),
      .rf_a       (rf_a),
      .rf_b       (rf_b),
      .wb_valid   (wb_valid),
      .wb_addr    (wb_addr),
      .id_valid   (id_valid),
      .ex_ready   (ex_ready),
      .id_opcode  (id_opcode),
      .id_rd      (id_rd),
      .id_op_a    (id_op_a),
      .id_op_b    (id_op_b),
      .id_pc      (id_pc),
      .id_illegal (id_illegal),
      .stall_cnt  (stall_cnt)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b0; if_valid = 1'b0; if_instr = 16'h1298; if_pc = 16'h0;
      rf_a = '0; rf_b = '0; wb_valid = 1'b0; wb_addr = '0; ex_ready = 1'b1;
      tick; tick;
      reset = 1'b1;
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
      n_checks++; if (id_opcode !== 4'h0) begin n_fail++; $display("FAIL reset_opcode got=%h exp=0", id_opcode); end
      n_checks++; if (id_op_a !== 16'h0) begin n_fail++; $display("FAIL reset_op_a got=%h exp=0", id_op_a); end
      n_checks++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_stall got=%h exp=0", stall_cnt); end
      n_checks++; if (id_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got=%b exp=0", id_illegal); end
      n_checks++; if ({rf_ra, rf_rb} !== {3'd2, 3'd3}) begin n_fail++; $display("FAIL raddr_r got=%0d/%0d exp=2/3", rf_ra, rf_rb); end
      if_instr = 16'h7AC0; // BEQ rs1=3, rs2=5 in [11:9]
      #1;
      n_checks++; if ({rf_ra, rf_rb} !== {3'd3, 3'd5}) begin n_fail++; $display("FAIL raddr_beq got=%0d/%0d exp=3/5", rf_ra, rf_rb); end
   endtask

   task automatic test_add;
      if_instr = 16'h1298; if_valid = 1'b1; rf_a = 16'd5; rf_b = 16'd8; if_pc = 16'h0100;
      @(negedge clk);
      n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready got=%b exp=1", if_ready); end
      tick;
      if_valid = 1'b0;
      n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got=%b exp=1", id_valid); end
      n_checks++; if ({id_opcode, id_rd} !== {4'd1, 3'd1}) begin n_fail++; $display("FAIL add_op_rd got=%h/%h exp=1/1", id_opcode, id_rd); end
      n_checks++; if ({id_op_a, id_op_b} !== {16'd5, 16'd8}) begin n_fail++; $display("FAIL add_ops got=%h/%h exp=5/8", id_op_a, id_op_b); end
      n_checks++; if (id_pc !== 16'h0100) begin n_fail++; $display("FAIL add_pc got=%h exp=0100", id_pc); end
   endtask

   task automatic test_raw_stall;
      if_instr = 16'h1850; if_valid = 1'b1; rf_a = 16'd7; rf_b = 16'd9; if_pc = 16'h0102;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL raw_ready[%0d] got=%b exp=0", i, if_ready); end
         tick;
      end
      n_checks++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL raw_stall3 got=%0d exp=3", stall_cnt); end
      wb_valid = 1'b1; wb_addr = 3'd1;
      @(negedge clk);
      n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL raw_wb_same got=%b exp=0", if_ready); end
      tick;
      wb_valid = 1'b0;
      n_checks++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL raw_stall4 got=%0d exp=4", stall_cnt); end
      @(negedge clk);
      n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL raw_after_wb got=%b exp=1", if_ready); end
      tick;
      if_valid = 1'b0;
      n_checks++; if ({id_valid, id_rd} !== {1'b1, 3'd4}) begin n_fail++; $display("FAIL raw_rd got=%b/%0d exp=1/4", id_valid, id_rd); end
      n_checks++; if ({id_op_a, id_op_b, id_pc} !== {16'd7, 16'd9, 16'h0102}) begin n_fail++; $display("FAIL raw_data got=%h/%h/%h exp=7/9/0102", id_op_a, id_op_b, id_pc); end
      n_checks++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL raw_stall_hold got=%0d exp=4", stall_cnt); end
   endtask

   task automatic test_addi;
      if_instr = 16'h1048; if_valid = 1'b1; rf_a = 16'd3; rf_b = 16'd3; // ADD r0,r1,r1
      tick;
      if_instr = 16'h543F; rf_a = 16'd0; rf_b = 16'h1234; if_pc = 16'h0104;
      @(negedge clk);
      n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL addi_r0_ready got=%b exp=1", if_ready); end
      tick;
      n_checks++; if ({id_opcode, id_rd} !== {4'd5, 3'd2}) begin n_fail++; $display("FAIL addi_op_rd got=%h/%h exp=5/2", id_opcode, id_rd); end
      n_checks++; if ({id_op_a, id_op_b} !== {16'h0000, 16'hFFFF}) begin n_fail++; $display("FAIL addi_ops got=%h/%h exp=0000/ffff", id_op_a, id_op_b); end
      if_instr = 16'h1680; // ADD r3,r2,r0 must see r2 pending
      @(negedge clk);
      n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL addi_r2_pending got=%b exp=0", if_ready); end
      if_valid = 1'b0;
      wb_valid = 1'b1; wb_addr = 3'd4;
      tick;
      wb_addr = 3'd2;
      tick;
      wb_valid = 1'b0;
   endtask

   task automatic test_backpressure;
      ex_ready = 1'b0;
      if_instr = 16'h3BB8; if_valid = 1'b1; rf_a = 16'h00AA; rf_b = 16'h0055; if_pc = 16'h0200;
      @(negedge clk);
      n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first_ready got=%b exp=1", if_ready); end
      tick;
      if_instr = 16'h4C50; rf_a = 16'h0011; rf_b = 16'h0022; if_pc = 16'h0202;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, if_ready); end
         n_checks++; if ({id_valid, id_opcode, id_rd, id_op_a, id_op_b, id_pc} !== {1'b1, 4'd3, 3'd5, 16'h00AA, 16'h0055, 16'h0200})
            begin n_fail++; $display("FAIL bp_hold[%0d] got=%b/%h/%h/%h/%h/%h", i, id_valid, id_opcode, id_rd, id_op_a, id_op_b, id_pc); end
         tick;
      end
      n_checks++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL bp_stall got=%0d exp=4", stall_cnt); end
      ex_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got=%b exp=1", if_ready); end
      tick;
      if_valid = 1'b0;
      n_checks++; if ({id_opcode, id_rd, id_op_a, id_op_b, id_pc} !== {4'd4, 3'd6, 16'h0011, 16'h0022, 16'h0202})
         begin n_fail++; $display("FAIL bp_next got=%h/%h/%h/%h/%h", id_opcode, id_rd, id_op_a, id_op_b, id_pc); end
   endtask

   task automatic test_illegal;
      if_instr = 16'hCE00; if_valid = 1'b1; if_pc = 16'h0300;
      @(negedge clk);
      n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL ill_ready got=%b exp=1", if_ready); end
      tick;
      n_checks++; if ({id_valid, id_illegal} !== 2'b11) begin n_fail++; $display("FAIL ill_flag got=%b/%b exp=1/1", id_valid, id_illegal); end
      if_instr = 16'h13F8; rf_a = 16'd1; rf_b = 16'd1; // reads r7
      @(negedge clk);
      n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL ill_no_pending got=%b exp=1", if_ready); end
      tick;
      if_valid = 1'b0;
      n_checks++; if ({id_illegal, id_opcode} !== {1'b0, 4'd1}) begin n_fail++; $display("FAIL ill_next got=%b/%h exp=0/1", id_illegal, id_opcode); end
      n_checks++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL ill_stall got=%0d exp=4", stall_cnt); end
   endtask

   task automatic test_reset_mid;
      wb_valid = 1'b1; wb_addr = 3'd1; tick;
      wb_addr = 3'd5; tick;
      wb_addr = 3'd6; tick;
      wb_valid = 1'b0;
      if_instr = 16'h1298; if_valid = 1'b1; rf_a = 16'd5; rf_b = 16'd8; tick;
      if_instr = 16'h543F; rf_a = 16'd0; tick;
      if_valid = 1'b0; ex_ready = 1'b0;
      n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got=%b exp=1", id_valid); end
      reset = 1'b0;
      tick;
      reset = 1'b1;
      n_checks++; if ({id_valid, id_illegal, id_opcode, id_rd, id_op_a, id_op_b, id_pc, stall_cnt} !== '0)
         begin n_fail++; $display("FAIL mid_reset got=%b/%b/%h/%h/%h/%h/%h/%h", id_valid, id_illegal, id_opcode, id_rd, id_op_a, id_op_b, id_pc, stall_cnt); end
      ex_ready = 1'b1;
      if_instr = 16'h1650; if_valid = 1'b1; // reads r1, r2
      @(negedge clk);
      n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL mid_sb_clear got=%b exp=1", if_ready); end
      tick;
      if_valid = 1'b0;
      n_checks++; if (id_rd !== 3'd3) begin n_fail++; $display("FAIL mid_after_rd got=%0d exp=3", id_rd); end
   endtask

   initial begin
      test_reset;
      test_add;
      test_raw_stall;
      test_addi;
      test_backpressure;
      test_illegal;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
